ps2_kb_receiver: RTL and testbench
==================================

// Module: ps2_kb_receiver
// PURPOSE
//  PS/2 keyboard front end, directly upstream of the keyboard port controller.
//  Receives 11-bit frames from the keyboard, checks start, parity and stop bits,
//  and folds E0/F0 prefixes into one 16-bit scan-code word (KBBuffer).
//  Holds a valid flag until the controller acknowledges it with its read strobe.
// PARAMETERS
//  FILTER_LEN   8      CLK cycles PS2_CLK must be stable before a level change is accepted
//  TIMEOUT_CYC  50000  CLK cycles allowed between falling edges inside a frame before abort
// PORTS
//  CLK        in   1   system clock; all logic is on the rising edge
//  RESET_N    in   1   asynchronous, active-low reset
//  PS2_CLK    in   1   raw PS/2 clock line (asynchronous, idles high)
//  PS2_DATA   in   1   raw PS/2 data line (asynchronous, idles high)
//  KB_ACK     in   1   1-cycle pulse from the consumer: current word has been read
//  KBBuffer   out  16  [15:8] flags {6'b0, EXT, BRK}; [7:0] scan code
//  KB_Valid   out  1   KBBuffer holds an unread word
//  KB_Ovf     out  1   sticky: an unread word was overwritten
//  KB_Err     out  1   1-cycle pulse on parity, stop or timeout error
// BEHAVIOUR
//  Reset: KBBuffer=0, KB_Valid=0, KB_Ovf=0, KB_Err=0.
//   Frame FSM goes to IDLE; prefix flags cleared; filter state preset to 1 (idle bus).
//  Input conditioning:
//   - 2-FF synchroniser on both lines.
//   - PS2_CLK passes a FILTER_LEN stability filter.
//   - A filtered 1->0 transition gives a 1-cycle fall strobe; data is sampled from the synchronised PS2_DATA on that strobe.
//  Frame FSM (advances only on a fall strobe):
//   - IDLE: data=0 -> DATA with bit count 0; data=1 -> stay in IDLE, no error.
//   - DATA: shift data in, LSB first. Count 0..7; after bit 7 -> PARITY.
//   - PARITY: store the parity bit -> STOP.
//   - STOP: goes to IDLE.
//     Frame OK when stop=1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity).
//     OK -> byte_rdy pulse for one cycle. Otherwise KB_Err pulse; byte discarded.
//  Timeout:
//   - Counter clears on every fall strobe and whenever the FSM is in IDLE.
//   - At TIMEOUT_CYC while not in IDLE: FSM -> IDLE, KB_Err pulse. Prefix flags are kept.
//  Assembler (acts on byte_rdy):
//   - 8'hE0 -> EXT=1; 8'hF0 -> BRK=1. No output change.
//   - Any other byte -> KBBuffer <= {6'b0, EXT, BRK, byte}; KB_Valid <= 1; then EXT=BRK=0.
//  Handshake:
//   - KB_ACK clears KB_Valid and KB_Ovf on the next edge.
//   - New word while KB_Valid=1 and no KB_ACK: overwrite, KB_Ovf <= 1.
//   - New word and KB_ACK in the same cycle: the new word wins, KB_Valid stays 1, KB_Ovf <= 0.
//   - KB_ACK while KB_Valid=0: ignored.
//  Latency: KB_Valid rises FILTER_LEN+4 CLK cycles after the stop-bit falling edge on the pin.
//  Reset asserted mid-frame: immediate abort. No partial word is ever output.
// STRUCTURE
//  ps2_pkg holds:
//   - frame FSM state encoding (IDLE, DATA, PARITY, STOP)
//   - constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0
//   - flag bit indices FLAG_BRK=8 and FLAG_EXT=9
//  Sub-module ps2_line_filter: synchroniser, FILTER_LEN filter and fall-strobe generator for PS2_CLK.
//  Frame FSM, timeout counter, assembler and handshake stay in this module.
// TESTING
//  1 Hold RESET_N=0 with both lines high, release, idle 100 cycles
//     -> all outputs 0, no KB_Err.
//  2 Frame 0x1C (parity 0, stop 1)
//     -> KBBuffer=16'h001C, KB_Valid=1 until KB_ACK, then 0.
//  3 Frames F0,1C
//     -> 16'h011C.
//    Frames E0,F0,75
//     -> 16'h0375.
//    Then frame 29
//     -> 16'h0029 (flags cleared).
//  4 Frame 0x1C with parity=1
//     -> one KB_Err pulse; KB_Valid and KBBuffer unchanged.
//    Then frame 0x1C with stop=0
//     -> same response.
//  5 Stop after 5 data bits, idle TIMEOUT_CYC+2 cycles
//     -> one KB_Err pulse, FSM back in IDLE.
//    Then a good frame 0x29
//     -> 16'h0029.
//  6 Frames 1C then 32 with no KB_ACK
//     -> KBBuffer=16'h0032, KB_Ovf=1.
//    Then KB_ACK
//     -> KB_Valid=0, KB_Ovf=0.
//    Then KB_ACK in the same cycle as a new word 1B
//     -> KB_Valid=1, KBBuffer=16'h001B.

Source files
------------

// File: rtl/ps2_kb_receiver_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_kb_receiver_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } frame_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int unsigned FLAG_BRK = 8;
  localparam int unsigned FLAG_EXT = 9;

  // Odd parity: the 8 data bits plus the parity bit must XOR to 1.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_kb_receiver_if.sv
// PS/2 lines, consumer handshake and received-word outputs of the keyboard receiver.
interface ps2_kb_receiver_if;

  logic        ps2_clk;
  logic        ps2_data;
  logic        kb_ack;
  logic [15:0] kb_buffer;
  logic        kb_valid;
  logic        kb_ovf;
  logic        kb_err;

  // master: keyboard lines + consumer; slave: the receiver
  modport master (
    output ps2_clk, ps2_data, kb_ack,
    input  kb_buffer, kb_valid, kb_ovf, kb_err
  );

  modport slave (
    input  ps2_clk, ps2_data, kb_ack,
    output kb_buffer, kb_valid, kb_ovf, kb_err
  );

endinterface

// File: rtl/ps2_kb_receiver_line_filter.sv
// Synchronises both PS/2 lines, debounces PS2_CLK and emits a one-cycle strobe on each
// accepted falling edge of the filtered clock.
module ps2_kb_receiver_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_data_sync,
  output logic o_fall
);

  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_LEN - 1);

  logic            r_clk_meta;
  logic            r_clk_sync;
  logic            r_data_meta;
  logic            r_data_sync;
  logic            r_clk_filt;
  logic [CntW-1:0] r_cnt;
  logic            r_fall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
    end else begin
      r_clk_meta  <= i_ps2_clk;
      r_clk_sync  <= r_clk_meta;
      r_data_meta <= i_ps2_data;
      r_data_sync <= r_data_meta;
    end
  end

  // A new level is accepted only after it has differed from the filtered level
  // for FILTER_LEN consecutive cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_filt <= 1'b1;
      r_cnt      <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (r_clk_sync == r_clk_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CntMax) begin
        r_clk_filt <= r_clk_sync;
        r_cnt      <= '0;
        r_fall     <= ~r_clk_sync;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_data_sync = r_data_sync;
  assign o_fall      = r_fall;

endmodule

// File: rtl/ps2_kb_receiver.sv
// PS/2 keyboard receiver: frame checking, E0/F0 prefix folding into a 16-bit word,
// and a valid/ack handshake towards the keyboard port controller.
module ps2_kb_receiver #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input logic          i_clk,
  input logic          i_rst_n,
  ps2_kb_receiver_if.slave bus
);

  import ps2_kb_receiver_pkg::*;

  localparam int unsigned ToW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [ToW-1:0] ToMax = ToW'(TIMEOUT_CYC - 1);

  logic w_data;
  logic w_fall;

  ps2_kb_receiver_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_line_filter (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_ps2_clk   (bus.ps2_clk),
    .i_ps2_data  (bus.ps2_data),
    .o_data_sync (w_data),
    .o_fall      (w_fall)
  );

  frame_state_e r_state, w_state_d;
  logic [2:0]     r_bit_cnt, w_bit_cnt_d;
  logic [7:0]     r_shift, w_shift_d;
  logic           r_parity, w_parity_d;
  logic [ToW-1:0] r_to_cnt;
  logic           w_timeout;
  logic           w_byte_rdy_d;
  logic           w_err_d;
  logic           r_byte_rdy;
  logic [7:0]     r_byte;
  logic           r_err;

  assign w_timeout = (r_state != StIdle) && (r_to_cnt == ToMax);

  always_comb begin
    w_state_d    = r_state;
    w_bit_cnt_d  = r_bit_cnt;
    w_shift_d    = r_shift;
    w_parity_d   = r_parity;
    w_byte_rdy_d = 1'b0;
    w_err_d      = 1'b0;
    if (w_fall) begin
      case (r_state)
        StIdle: begin
          if (!w_data) begin
            w_state_d   = StData;
            w_bit_cnt_d = 3'd0;
          end
        end
        StData: begin
          w_shift_d = {w_data, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) begin
            w_state_d = StParity;
          end else begin
            w_bit_cnt_d = r_bit_cnt + 3'd1;
          end
        end
        StParity: begin
          w_parity_d = w_data;
          w_state_d  = StStop;
        end
        StStop: begin
          w_state_d = StIdle;
          if (w_data && odd_parity_ok(r_shift, r_parity)) begin
            w_byte_rdy_d = 1'b1;
          end else begin
            w_err_d = 1'b1;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end else if (w_timeout) begin
      w_state_d = StIdle;
      w_err_d   = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_to_cnt   <= '0;
      r_byte_rdy <= 1'b0;
      r_byte     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_bit_cnt  <= w_bit_cnt_d;
      r_shift    <= w_shift_d;
      r_parity   <= w_parity_d;
      r_byte_rdy <= w_byte_rdy_d;
      r_err      <= w_err_d;
      if (w_byte_rdy_d) begin
        r_byte <= r_shift;
      end
      if ((r_state == StIdle) || w_fall) begin
        r_to_cnt <= '0;
      end else if (!w_timeout) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  logic        r_ext;
  logic        r_brk;
  logic [15:0] r_buf;
  logic        r_valid;
  logic        r_ovf;
  logic        w_new_word;
  logic [15:0] w_word;

  assign w_new_word = r_byte_rdy && (r_byte != PS2_EXT) && (r_byte != PS2_BRK);

  always_comb begin
    w_word           = '0;
    w_word[7:0]      = r_byte;
    w_word[FLAG_EXT] = r_ext;
    w_word[FLAG_BRK] = r_brk;
  end

  // Prefix flags survive a timeout; only a complete non-prefix byte consumes them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ext   <= 1'b0;
      r_brk   <= 1'b0;
      r_buf   <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (r_byte_rdy && (r_byte == PS2_EXT)) begin
        r_ext <= 1'b1;
      end else if (r_byte_rdy && (r_byte == PS2_BRK)) begin
        r_brk <= 1'b1;
      end else if (w_new_word) begin
        r_buf <= w_word;
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
      if (w_new_word) begin
        r_valid <= 1'b1;
        if (bus.kb_ack) begin
          r_ovf <= 1'b0;
        end else if (r_valid) begin
          r_ovf <= 1'b1;
        end
      end else if (bus.kb_ack && r_valid) begin
        r_valid <= 1'b0;
        r_ovf   <= 1'b0;
      end
    end
  end

  assign bus.kb_buffer = r_buf;
  assign bus.kb_valid  = r_valid;
  assign bus.kb_ovf    = r_ovf;
  assign bus.kb_err    = r_err;

endmodule

// File: tb/tb_ps2_kb_receiver.sv
// Self-checking bench for ps2_kb_receiver: directed vector table, corner-case sequences
// and random frames checked against a frame-level reference model.
module tb_ps2_kb_receiver;

  localparam int unsigned FLT = 8;
  localparam int unsigned TO  = 3000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_kb_receiver_if bus ();

  ps2_kb_receiver #(
    .FILTER_LEN  (FLT),
    .TIMEOUT_CYC (TO)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int err_cnt = 0;
  int lat = -1;

  always @(negedge clk) if (bus.kb_err === 1'b1) err_cnt <= err_cnt + 1;

  // Frame-level reference model
  logic [15:0] m_buf;
  bit          m_valid, m_ovf, m_ext, m_brk;
  int          m_errs;

  function automatic void model_reset();
    m_buf = 16'h0; m_valid = 0; m_ovf = 0; m_ext = 0; m_brk = 0; m_errs = 0;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input bit bp, input bit bs);
    if (bp || bs) m_errs++;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      m_buf = {6'b0, m_ext, m_brk, b};
      if (m_valid) m_ovf = 1;
      m_valid = 1; m_ext = 0; m_brk = 0;
    end
  endfunction

  function automatic void model_ack();
    if (m_valid) begin m_valid = 0; m_ovf = 0; end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode 0: plain bit; 1: pulse KB_ACK on the edge the word lands; 2: measure latency
  task automatic send_bit(input logic v, input int mode);
    bus.ps2_data = v;
    idle(20);
    bus.ps2_clk = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mode == 1 && i == int'(FLT) + 3) bus.kb_ack = 1'b1;
      @(posedge clk);
      #1;
      bus.kb_ack = 1'b0;
      if (mode == 2 && lat < 0 && bus.kb_valid === 1'b1) lat = i + 1;
    end
    bus.ps2_clk = 1'b1;
    idle(20);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bp, input bit bs, input int nbits,
                            input int mode);
    logic [10:0] bits;
    bits = {~bs, (~^b) ^ bp, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(bits[i], (i == 10) ? mode : 0);
    bus.ps2_data = 1'b1;
    idle(60);
  endtask

  task automatic ack();
    bus.kb_ack = 1'b1;
    idle(1);
    bus.kb_ack = 1'b0;
    idle(2);
  endtask

  typedef struct {
    logic [7:0]  data;
    bit          bad_par;
    bit          bad_stop;
    bit          ack_after;
    logic [15:0] exp_buf;
    bit          exp_valid;
    bit          exp_ovf;
    int          exp_err;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int e0;
    tbl[0]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 16'h001C, 1'b1, 1'b0, 0};
    tbl[1]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 16'h001C, 1'b0, 1'b0, 0};
    tbl[2]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 16'h011C, 1'b1, 1'b0, 0};
    tbl[3]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 16'h011C, 1'b0, 1'b0, 0};
    tbl[4]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 16'h011C, 1'b0, 1'b0, 0};
    tbl[5]  = '{8'h75, 1'b0, 1'b0, 1'b1, 16'h0375, 1'b1, 1'b0, 0};
    tbl[6]  = '{8'h29, 1'b0, 1'b0, 1'b0, 16'h0029, 1'b1, 1'b0, 0};
    tbl[7]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 16'h0029, 1'b1, 1'b0, 1};
    tbl[8]  = '{8'h1C, 1'b0, 1'b1, 1'b1, 16'h0029, 1'b1, 1'b0, 1};
    tbl[9]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 16'h001C, 1'b1, 1'b0, 0};
    tbl[10] = '{8'h32, 1'b0, 1'b0, 1'b1, 16'h0032, 1'b1, 1'b1, 0};

    bus.ps2_clk = 1'b1; bus.ps2_data = 1'b1; bus.kb_ack = 1'b0;
    rst_n = 1'b0;
    idle(10);
    rst_n = 1'b1;
    idle(100);
    check("reset_buf", bus.kb_buffer, 16'h0);
    check("reset_valid", bus.kb_valid, 1'b0);
    check("reset_ovf", bus.kb_ovf, 1'b0);
    check("reset_err", err_cnt, 0);

    for (int i = 0; i < 11; i++) begin
      e0 = err_cnt;
      send_frame(tbl[i].data, tbl[i].bad_par, tbl[i].bad_stop, 11, 0);
      check($sformatf("vec%0d_buf", i), bus.kb_buffer, tbl[i].exp_buf);
      check($sformatf("vec%0d_valid", i), bus.kb_valid, tbl[i].exp_valid);
      check($sformatf("vec%0d_ovf", i), bus.kb_ovf, tbl[i].exp_ovf);
      check($sformatf("vec%0d_err", i), err_cnt - e0, tbl[i].exp_err);
      if (tbl[i].ack_after) begin
        ack();
        check($sformatf("vec%0d_ack_valid", i), bus.kb_valid, 1'b0);
        check($sformatf("vec%0d_ack_ovf", i), bus.kb_ovf, 1'b0);
      end
    end

    // Latency from the stop-bit falling edge to KB_Valid
    lat = -1;
    send_frame(8'h2A, 1'b0, 1'b0, 11, 2);
    check("latency", lat, FLT + 4);
    check("latency_buf", bus.kb_buffer, 16'h002A);
    ack();

    // Truncated frame: timeout abort, then a good frame
    e0 = err_cnt;
    send_frame(8'h29, 1'b0, 1'b0, 6, 0);
    idle(TO + 2);
    check("timeout_err", err_cnt - e0, 1);
    check("timeout_valid", bus.kb_valid, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0, 11, 0);
    check("after_to_buf", bus.kb_buffer, 16'h0029);
    check("after_to_valid", bus.kb_valid, 1'b1);
    check("after_to_err", err_cnt - e0, 1);
    ack();

    // KB_ACK coinciding with a new word: new word wins, no overflow
    send_frame(8'h1C, 1'b0, 1'b0, 11, 0);
    check("pre_sim_valid", bus.kb_valid, 1'b1);
    send_frame(8'h1B, 1'b0, 1'b0, 11, 1);
    check("sim_buf", bus.kb_buffer, 16'h001B);
    check("sim_valid", bus.kb_valid, 1'b1);
    check("sim_ovf", bus.kb_ovf, 1'b0);

    // Reset mid-frame: abort without output or error
    send_frame(8'h55, 1'b0, 1'b0, 4, 0);
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(20);
    model_reset();
    check("midrst_valid", bus.kb_valid, 1'b0);
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b0, 11, 0);
    model_frame(8'h1C, 1'b0, 1'b0);
    check("midrst_buf", bus.kb_buffer, m_buf);
    check("midrst_err", err_cnt - e0, 0);

    // Random frames against the reference model
    for (int n = 0; n < 20; n++) begin
      logic [7:0] b;
      bit bp, bs;
      int r;
      r = $urandom_range(0, 5);
      b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
      bp = ($urandom_range(0, 7) == 0);
      bs = !bp && ($urandom_range(0, 7) == 0);
      send_frame(b, bp, bs, 11, 0);
      model_frame(b, bp, bs);
      check($sformatf("rnd%0d_buf", n), bus.kb_buffer, m_buf);
      check($sformatf("rnd%0d_valid", n), bus.kb_valid, m_valid);
      check($sformatf("rnd%0d_ovf", n), bus.kb_ovf, m_ovf);
      check($sformatf("rnd%0d_err", n), err_cnt - e0, m_errs);
      if ($urandom_range(0, 1) == 1) begin
        ack();
        model_ack();
        check($sformatf("rnd%0d_ack_valid", n), bus.kb_valid, m_valid);
        check($sformatf("rnd%0d_ack_ovf", n), bus.kb_ovf, m_ovf);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
